if_fetch_unit: RTL

- Front end of the 5-stage RV32I pipeline: owns the PC, issues instruction-memory requests and buffers returned words.
- Presents instructions to the ID stage over a valid/ready handshake.
- Consumes the EX-stage redirect (branch-taken flag plus next PC). This is the receiving end of the branch/flush path that EX drives.

---
 rtl/if_fetch_unit_pkg.sv | 22 ++
 rtl/if_fifo.sv | 64 ++++++
 rtl/if_fetch_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: constants and types shared by the instruction fetch unit.
//   XLEN         - datapath width of the RV32I core
//   RESET_PC_DEF - default first fetch address after reset
//   INST_NOP     - canonical RV32I NOP (addi x0, x0, 0) shown when no instruction is available
//   fetch_state_e - BOOT/RUN states of the fetch controller
//   align_word   - forces an address onto a 4-byte boundary
package if_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_NOP     = 32'h0000_0013;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fifo.sv
// if_fifo: synchronous FIFO with a single-cycle flush, used both as the
// instruction buffer ({pc, inst}) and as the PC-tag queue of in-flight requests.
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-high reset
//   flush           - empties the FIFO at the clock edge (wins over push/pop)
//   push, wdata     - write request and payload (ignored when full and not popping)
//   pop             - remove the head entry (ignored when empty)
//   rdata           - head entry, valid whenever empty=0
//   count/full/empty- occupancy status
// Any DEPTH >= 2 works; pointers wrap explicitly rather than relying on powers of two.
module if_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read once count says they were written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage of the 5-stage RV32I pipeline. Owns the PC, issues
// instruction-memory requests, tags them with their PC, buffers returned words
// and hands them to ID over valid/ready. EX redirects flush the buffer and
// discard every response still in flight.
// Ports:
//   clk, rst                    - rising-edge clock, asynchronous active-high reset
//   ex_branch_i, ex_next_pc_i   - redirect strobe and target from EX
//   imem_req_o, imem_addr_o     - fetch request and word-aligned address
//   imem_gnt_i                  - request accepted this cycle
//   imem_rvalid_i, imem_rdata_i - in-order read response
//   if_valid_o, if_inst_o, if_pc_o - instruction presented to ID (NOP / pc 0 when none)
//   id_ready_i                  - ID consumes the presented instruction
// Build option: define IF_BYPASS_EN to forward a response straight to ID when the
// buffer is empty, saving one cycle of fetch latency.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int              FIFO_DEPTH = 2,
  parameter int              MAX_OUTST  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_branch_i,
  input  logic [XLEN-1:0] ex_next_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_inst_o,
  output logic [XLEN-1:0] if_pc_o,
  input  logic            id_ready_i
);

  localparam int OW  = $clog2(MAX_OUTST + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e      state, state_next;
  logic              run;
  logic [XLEN-1:0]   pc, pc_next;
  logic [OW-1:0]     outst, outst_next;
  logic [OW-1:0]     drop, drop_next;

  logic              issue_fire;
  logic              resp_drop;
  logic              resp_keep;
  logic              bypass_hit;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FCW-1:0]    fifo_count;
  logic [2*XLEN-1:0] fifo_rdata;

  logic              tag_pop, tag_full, tag_empty;
  logic [OW-1:0]     tag_count;
  logic [XLEN-1:0]   tag_rdata;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_BOOT;
    else     state <= state_next;
  end

  // FSM next state: BOOT lasts exactly one cycle
  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_BOOT;
    endcase
  end

  // FSM outputs
  always_comb begin
    run = 1'b0;
    if (state == ST_RUN) run = 1'b1;
  end

  // Every in-flight request owns a buffer slot, so the FIFO can never overflow.
  assign imem_req_o  = run
                       && ((int'(outst) + int'(fifo_count)) < FIFO_DEPTH)
                       && (int'(outst) < MAX_OUTST);
  assign imem_addr_o = pc;
  assign issue_fire  = imem_req_o && imem_gnt_i;

  // A response arriving in the redirect cycle is wrong-path by definition.
  assign resp_drop = imem_rvalid_i && (drop != '0);
  assign resp_keep = imem_rvalid_i && (drop == '0) && !ex_branch_i;

`ifdef IF_BYPASS_EN
  assign bypass_hit = fifo_empty && resp_keep;
  assign fifo_push  = resp_keep && !(bypass_hit && id_ready_i);
`else
  assign bypass_hit = 1'b0;
  assign fifo_push  = resp_keep;
`endif

  assign fifo_pop = !fifo_empty && id_ready_i;
  assign tag_pop  = imem_rvalid_i && !tag_empty;

  always_comb begin
    outst_next = outst;
    if (issue_fire) outst_next = outst_next + OW'(1);
    if (imem_rvalid_i && (outst != '0)) outst_next = outst_next - OW'(1);
  end

  // On redirect everything still outstanding after this edge is wrong-path,
  // including a request granted in the redirect cycle itself.
  always_comb begin
    drop_next = drop;
    if (resp_drop)   drop_next = drop - OW'(1);
    if (ex_branch_i) drop_next = outst_next;
  end

  always_comb begin
    pc_next = pc;
    if (issue_fire)  pc_next = pc + 32'd4;
    if (ex_branch_i) pc_next = align_word(ex_next_pc_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      outst <= '0;
      drop  <= '0;
    end else begin
      pc    <= pc_next;
      outst <= outst_next;
      drop  <= drop_next;
    end
  end

  always_comb begin
    if_valid_o = 1'b0;
    if_inst_o  = INST_NOP;
    if_pc_o    = '0;
    if (!fifo_empty) begin
      if_valid_o = 1'b1;
      if_pc_o    = fifo_rdata[2*XLEN-1:XLEN];
      if_inst_o  = fifo_rdata[XLEN-1:0];
    end else if (bypass_hit) begin
      if_valid_o = 1'b1;
      if_pc_o    = tag_rdata;
      if_inst_o  = imem_rdata_i;
    end
  end

  if_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2*XLEN)
  ) u_inst_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (ex_branch_i),
    .push  (fifo_push),
    .wdata ({tag_rdata, imem_rdata_i}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Tags are never flushed: dropped responses still retire their own tag.
  if_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (XLEN)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (issue_fire),
    .wdata (pc),
    .pop   (tag_pop),
    .rdata (tag_rdata),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  rvalid_needs_outst: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid_i |-> (outst != '0));
  tag_tracks_outst: assert property (@(posedge clk) disable iff (rst)
    tag_count == outst);
  drop_within_outst: assert property (@(posedge clk) disable iff (rst)
    drop <= outst);
  no_inst_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !fifo_pop && !ex_branch_i));
  no_tag_overflow: assert property (@(posedge clk) disable iff (rst)
    !(issue_fire && tag_full && !tag_pop));

endmodule
